// File: rtl/fatori_mon_err_log_if.sv
// Log record stream from the error monitor to its consumer.
//   log_valid_o  producer has a record on the bus
//   log_ready_i  consumer accepts the record (handshake on valid && ready)
//   log_src_o    source index of the record
//   log_kind_o   0 = minority, 1 = majority, 2 = scrub
//   log_ts_o     timestamp captured when the record entered the FIFO
interface fatori_mon_err_log_if #(
  parameter int unsigned NSRC = 4,
  parameter int unsigned CW   = 16
);
  localparam int unsigned SW = (NSRC > 1) ? $clog2(NSRC) : 1;

  logic          log_valid_o;
  logic          log_ready_i;
  logic [SW-1:0] log_src_o;
  logic [1:0]    log_kind_o;
  logic [CW-1:0] log_ts_o;

  modport master (
    output log_valid_o,
    output log_src_o,
    output log_kind_o,
    output log_ts_o,
    input  log_ready_i
  );

  modport slave (
    input  log_valid_o,
    input  log_src_o,
    input  log_kind_o,
    input  log_ts_o,
    output log_ready_i
  );
endinterface

// File: rtl/fatori_mon_err_log.sv
// Error event monitor for NSRC voter wrappers.
// Rising edges on the minority / majority / scrub levels are counted per
// source (saturating), flagged as pending, and arbitrated one per cycle into
// a DEPTH-entry log FIFO with a free-running timestamp.
// Ports:
//   clk_i, rst_ni                 clock, asynchronous active-low reset
//   src_min_err_i/src_maj_err_i/src_scrub_i  per-source error levels
//   clr_i                         synchronous clear of counters, flags, pending, FIFO
//   log                           record stream (master side)
//   min_cnt_o/maj_cnt_o/scrub_cnt_o  packed counters, source s at [s*CW +: CW]
//   maj_sticky_o                  majority error seen since reset/clear
//   overflow_o                    record lost since reset/clear
module fatori_mon_err_log #(
  parameter int unsigned NSRC  = 4,
  parameter int unsigned CW    = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [NSRC-1:0]      src_min_err_i,
  input  logic [NSRC-1:0]      src_maj_err_i,
  input  logic [NSRC-1:0]      src_scrub_i,
  input  logic                 clr_i,
  fatori_mon_err_log_if.master log,
  output logic [NSRC*CW-1:0]   min_cnt_o,
  output logic [NSRC*CW-1:0]   maj_cnt_o,
  output logic [NSRC*CW-1:0]   scrub_cnt_o,
  output logic                 maj_sticky_o,
  output logic                 overflow_o
);
  localparam int unsigned SW = (NSRC > 1) ? $clog2(NSRC) : 1;
  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0]   PTR_ONE = {{AW{1'b0}}, 1'b1};
  localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    KIND_MIN   = 2'd0,
    KIND_MAJ   = 2'd1,
    KIND_SCRUB = 2'd2
  } kind_e;

  logic [NSRC-1:0] min_q, maj_q, scr_q;
  logic [NSRC-1:0] ev_min, ev_maj, ev_scr;
  logic [NSRC-1:0] pend_min, pend_maj, pend_scr;
  logic [NSRC-1:0] gnt_min, gnt_maj, gnt_scr;
  logic            push, pop, full, empty, can_push, lost;
  logic [SW-1:0]   push_src;
  kind_e           push_kind;
  logic [CW-1:0]   ts_q;
  logic [AW:0]     wr_ptr, rd_ptr;
  logic [SW-1:0]   mem_src  [DEPTH];
  logic [1:0]      mem_kind [DEPTH];
  logic [CW-1:0]   mem_ts   [DEPTH];

  assign ev_min = src_min_err_i & ~min_q;
  assign ev_maj = src_maj_err_i & ~maj_q;
  assign ev_scr = src_scrub_i   & ~scr_q;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop      = !empty && log.log_ready_i;
  assign can_push = !full || pop;

  // A repeat event only loses a record if its pending bit is not being
  // pushed this cycle; when it is, the new event simply re-arms the bit.
  assign lost = |(ev_min & pend_min & ~gnt_min) |
                |(ev_maj & pend_maj & ~gnt_maj) |
                |(ev_scr & pend_scr & ~gnt_scr);

  // Priority: majority, then minority, then scrub; lowest source first.
  always_comb begin
    gnt_min   = '0;
    gnt_maj   = '0;
    gnt_scr   = '0;
    push      = 1'b0;
    push_src  = '0;
    push_kind = KIND_MIN;
    if (can_push && !clr_i) begin
      for (int unsigned s = 0; s < NSRC; s++) begin
        if (!push && pend_maj[s]) begin
          push = 1'b1; push_src = SW'(s); push_kind = KIND_MAJ; gnt_maj[s] = 1'b1;
        end
      end
      for (int unsigned s = 0; s < NSRC; s++) begin
        if (!push && pend_min[s]) begin
          push = 1'b1; push_src = SW'(s); push_kind = KIND_MIN; gnt_min[s] = 1'b1;
        end
      end
      for (int unsigned s = 0; s < NSRC; s++) begin
        if (!push && pend_scr[s]) begin
          push = 1'b1; push_src = SW'(s); push_kind = KIND_SCRUB; gnt_scr[s] = 1'b1;
        end
      end
    end
  end

  // Edge-detect samples and timestamp keep running through clr_i.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      min_q <= '0;
      maj_q <= '0;
      scr_q <= '0;
      ts_q  <= '0;
    end else begin
      min_q <= src_min_err_i;
      maj_q <= src_maj_err_i;
      scr_q <= src_scrub_i;
      ts_q  <= ts_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      min_cnt_o    <= '0;
      maj_cnt_o    <= '0;
      scrub_cnt_o  <= '0;
      pend_min     <= '0;
      pend_maj     <= '0;
      pend_scr     <= '0;
      maj_sticky_o <= 1'b0;
      overflow_o   <= 1'b0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
    end else if (clr_i) begin
      min_cnt_o    <= '0;
      maj_cnt_o    <= '0;
      scrub_cnt_o  <= '0;
      pend_min     <= '0;
      pend_maj     <= '0;
      pend_scr     <= '0;
      maj_sticky_o <= 1'b0;
      overflow_o   <= 1'b0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
    end else begin
      pend_min <= (pend_min & ~gnt_min) | ev_min;
      pend_maj <= (pend_maj & ~gnt_maj) | ev_maj;
      pend_scr <= (pend_scr & ~gnt_scr) | ev_scr;
      if (|ev_maj) maj_sticky_o <= 1'b1;
      if (lost)    overflow_o   <= 1'b1;
      if (push)    wr_ptr       <= wr_ptr + PTR_ONE;
      if (pop)     rd_ptr       <= rd_ptr + PTR_ONE;
      for (int unsigned s = 0; s < NSRC; s++) begin
        if (ev_min[s] && (min_cnt_o[s*CW +: CW] != '1))
          min_cnt_o[s*CW +: CW] <= min_cnt_o[s*CW +: CW] + CNT_ONE;
        if (ev_maj[s] && (maj_cnt_o[s*CW +: CW] != '1))
          maj_cnt_o[s*CW +: CW] <= maj_cnt_o[s*CW +: CW] + CNT_ONE;
        if (ev_scr[s] && (scrub_cnt_o[s*CW +: CW] != '1))
          scrub_cnt_o[s*CW +: CW] <= scrub_cnt_o[s*CW +: CW] + CNT_ONE;
      end
    end
  end

  // Storage needs no reset: outputs are masked while the FIFO is empty.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_src[wr_ptr[AW-1:0]]  <= push_src;
      mem_kind[wr_ptr[AW-1:0]] <= push_kind;
      mem_ts[wr_ptr[AW-1:0]]   <= ts_q;
    end
  end

  always_comb begin
    log.log_valid_o = !empty;
    log.log_src_o   = empty ? '0 : mem_src[rd_ptr[AW-1:0]];
    log.log_kind_o  = empty ? '0 : mem_kind[rd_ptr[AW-1:0]];
    log.log_ts_o    = empty ? '0 : mem_ts[rd_ptr[AW-1:0]];
  end
endmodule
